// File: rtl/axi_mem_pkg.sv
// Shared constants and FSM encoding for the AXI-Lite memory slave.
// Imported by the top level; the bench keeps its own independent constants.
package axi_mem_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_ACC    = 3'd1,
        ST_RD_RESP   = 3'd2,
        ST_WR_RMW_RD = 3'd3,
        ST_WR_ACC    = 3'd4,
        ST_WR_RESP   = 3'd5
    } state_e;

endpackage

// File: rtl/axi_mem_byte_merge.sv
// Bytewise merge for partial writes: strobed bytes from the new word,
// all other bytes from the word read back from RAM.
module axi_mem_byte_merge #(
    parameter  int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] new_word,
    input  logic [STRB_W-1:0] strb,
    output logic [DATA_W-1:0] merged_word
);

    for (genvar b = 0; b < STRB_W; b++) begin : g_byte
        assign merged_word[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI-Lite slave in front of a single-port RAM; one outstanding transaction,
// round-robin between reads and writes, read-modify-write for partial strobes.
module axi_lite_mem_slave
    import axi_mem_pkg::*;
#(
    parameter  int ADDR_W = DEF_ADDR_W,
    parameter  int DATA_W = DEF_DATA_W,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [31:0]       AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [STRB_W-1:0] WSTRB,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [31:0]       ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              MEM_CS,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    state_e              state_q, state_d;
    logic                wr_prio_q, wr_prio_d;
    logic                mem_cs_q, mem_cs_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                wr_req, rd_req, wr_sel, rd_sel;
    logic                aw_oor, ar_oor;
    logic [ADDR_W-1:0]   aw_idx, ar_idx;
    logic [DATA_W-1:0]   merged_word;
    logic                unused_addr_lsb;

    assign wr_req = AWVALID && WVALID;
    assign rd_req = ARVALID;
    assign wr_sel = wr_req && (wr_prio_q || !rd_req);
    assign rd_sel = rd_req && !wr_sel;

    assign aw_idx = AWADDR[ADDR_W+1:2];
    assign ar_idx = ARADDR[ADDR_W+1:2];
    assign aw_oor = |AWADDR[31:ADDR_W+2];
    assign ar_oor = |ARADDR[31:ADDR_W+2];
    assign unused_addr_lsb = ^{AWADDR[1:0], ARADDR[1:0]};

    axi_mem_byte_merge #(.DATA_W(DATA_W)) u_merge (
        .old_word    (MEM_RDATA),
        .new_word    (wdata_q),
        .strb        (wstrb_q),
        .merged_word (merged_word)
    );

    // NOTE: every register, datapath included, is reset so all outputs read 0 in reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            wr_prio_q   <= 1'b1;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bresp_q     <= RESP_OKAY;
            rresp_q     <= RESP_OKAY;
            rdata_q     <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
            state_q     <= state_d;
            wr_prio_q   <= wr_prio_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bresp_q     <= bresp_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a _d unassigned and infers a latch.
        state_d     = state_q;
        wr_prio_d   = wr_prio_q;
        mem_cs_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bresp_d     = bresp_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (wr_sel) begin
                    wr_prio_d = 1'b0;
                    bresp_d   = RESP_OKAY;
                    if (aw_oor) begin
                        state_d = ST_WR_RESP;
                        bresp_d = RESP_SLVERR;
                    end else if (WSTRB == '0) begin
                        state_d = ST_WR_RESP;
                    end else begin
                        mem_cs_d   = 1'b1;
                        mem_addr_d = aw_idx;
                        if (&WSTRB) begin
                            state_d     = ST_WR_ACC;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = WDATA;
                        end else begin
                            state_d = ST_WR_RMW_RD;
                            wdata_d = WDATA;
                            wstrb_d = WSTRB;
                        end
                    end
                end else if (rd_sel) begin
                    wr_prio_d = 1'b1;
                    if (ar_oor) begin
                        state_d = ST_RD_RESP;
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end else begin
                        state_d    = ST_RD_ACC;
                        mem_cs_d   = 1'b1;
                        mem_addr_d = ar_idx;
                    end
                end
            end
            ST_RD_ACC: begin
                rdata_d = MEM_RDATA;
                rresp_d = RESP_OKAY;
                state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (RREADY) state_d = ST_IDLE;
            end
            ST_WR_RMW_RD: begin
                // Old word is on MEM_RDATA now; the write access follows directly.
                mem_cs_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_wdata_d = merged_word;
                state_d     = ST_WR_ACC;
            end
            ST_WR_ACC: begin
                state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (BREADY) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        ARREADY = 1'b0;
        BVALID  = (state_q == ST_WR_RESP);
        RVALID  = (state_q == ST_RD_RESP);
        // Readies are combinational on valids, so reset must mask them directly.
        if (state_q == ST_IDLE && RST_N) begin
            AWREADY = wr_sel;
            WREADY  = wr_sel;
            ARREADY = rd_sel;
        end
    end

    assign BRESP     = bresp_q;
    assign RRESP     = rresp_q;
    assign RDATA     = rdata_q;
    assign MEM_CS    = mem_cs_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Randomized bench for axi_lite_mem_slave: behavioural RAM on the memory port,
// transaction-level reference model for memory contents, latency and arbitration.
module tb_axi_lite_mem_slave;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [31:0] ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic        MEM_CS;
    logic        MEM_WE;
    logic [6:0]  MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [31:0] ram_rd = '0;

    axi_lite_mem_slave dut (
        .CLK(CLK), .RST_N(RST_N),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .MEM_CS(MEM_CS), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(ram_rd)
    );

    always #5 CLK = ~CLK;

    // Downstream RAM, sampling the strobes on the falling edge.
    logic [31:0] ram [128];
    int          cs_cnt = 0;
    int          we_cnt = 0;
    logic [6:0]  last_we_addr = '0;

    always @(negedge CLK) begin
        if (MEM_CS) begin
            cs_cnt++;
            if (MEM_WE) begin
                ram[MEM_ADDR] = MEM_WDATA;
                last_we_addr  = MEM_ADDR;
                we_cnt++;
            end else begin
                ram_rd <= ram[MEM_ADDR];
            end
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [128];
    bit          wr_prio = 1'b1;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        BREADY = 1'b0; RREADY = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        wr_prio = 1'b1;
    endtask

    task automatic drive_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        AWADDR = addr; WDATA = data; WSTRB = strb;
        AWVALID = 1'b1; WVALID = 1'b1;
        cs_cnt = 0; we_cnt = 0;
    endtask

    task automatic drive_r(input logic [31:0] addr);
        ARADDR = addr;
        ARVALID = 1'b1;
        cs_cnt = 0; we_cnt = 0;
    endtask

    // Called at a negedge with AW/W valid; returns at the negedge after the handshake edge.
    task automatic wait_w_accept(input string tag);
        int n = 0;
        #1;
        while (!(AWREADY && WREADY) && n < 50) begin
            @(negedge CLK); #1; n++;
        end
        check({tag, "_aw_accept"}, {31'b0, AWREADY && WREADY}, 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        AWVALID = 1'b0; WVALID = 1'b0;
    endtask

    task automatic wait_r_accept(input string tag);
        int n = 0;
        #1;
        while (!ARREADY && n < 50) begin
            @(negedge CLK); #1; n++;
        end
        check({tag, "_ar_accept"}, {31'b0, ARREADY}, 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        ARVALID = 1'b0;
    endtask

    task automatic finish_w(input string tag, input int exp_lat, input logic [1:0] exp_resp,
                            input int exp_cs, input int exp_we, input int hold);
        int lat = 1;
        while (!BVALID && lat < 20) begin
            @(posedge CLK); @(negedge CLK); lat++;
        end
        check({tag, "_blat"}, lat, exp_lat);
        check({tag, "_bresp"}, {30'b0, BRESP}, {30'b0, exp_resp});
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); @(negedge CLK);
            check({tag, "_bvalid_hold"}, {31'b0, BVALID}, 32'd1);
            check({tag, "_bresp_hold"}, {30'b0, BRESP}, {30'b0, exp_resp});
            check({tag, "_ready_low"}, {31'b0, ARREADY | AWREADY}, 32'd0);
        end
        BREADY = 1'b1;
        @(posedge CLK); @(negedge CLK);
        BREADY = 1'b0;
        check({tag, "_bvalid_drop"}, {31'b0, BVALID}, 32'd0);
        check({tag, "_cs_cycles"}, cs_cnt, exp_cs);
        check({tag, "_we_cycles"}, we_cnt, exp_we);
        cs_cnt = 0; we_cnt = 0;
    endtask

    task automatic finish_r(input string tag, input int exp_lat, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int exp_cs, input int hold);
        int lat = 1;
        while (!RVALID && lat < 20) begin
            @(posedge CLK); @(negedge CLK); lat++;
        end
        check({tag, "_rlat"}, lat, exp_lat);
        check({tag, "_rdata"}, RDATA, exp_data);
        check({tag, "_rresp"}, {30'b0, RRESP}, {30'b0, exp_resp});
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); @(negedge CLK);
            check({tag, "_rvalid_hold"}, {31'b0, RVALID}, 32'd1);
            check({tag, "_rdata_hold"}, RDATA, exp_data);
            check({tag, "_ready_low"}, {31'b0, ARREADY | AWREADY}, 32'd0);
        end
        RREADY = 1'b1;
        @(posedge CLK); @(negedge CLK);
        RREADY = 1'b0;
        check({tag, "_rvalid_drop"}, {31'b0, RVALID}, 32'd0);
        check({tag, "_cs_cycles"}, cs_cnt, exp_cs);
        check({tag, "_we_cycles"}, we_cnt, 0);
        cs_cnt = 0; we_cnt = 0;
    endtask

    // Model of one write: latency, response and RAM traffic follow from range and strobe.
    task automatic write_pending(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input int hold, input string tag);
        int         lat, ncs, nwe;
        logic [1:0] resp;
        int         idx = int'(addr[8:2]);
        if (addr[31:9] != '0) begin
            lat = 1; resp = SLVERR; ncs = 0; nwe = 0;
        end else if (strb == 4'h0) begin
            lat = 1; resp = OKAY; ncs = 0; nwe = 0;
        end else if (strb == 4'hF) begin
            lat = 2; resp = OKAY; ncs = 1; nwe = 1;
            ref_mem[idx] = data;
        end else begin
            lat = 3; resp = OKAY; ncs = 2; nwe = 1;
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
        end
        wr_prio = 1'b0;
        wait_w_accept(tag);
        finish_w(tag, lat, resp, ncs, nwe, hold);
    endtask

    task automatic read_pending(input logic [31:0] addr, input int hold, input string tag);
        int idx = int'(addr[8:2]);
        wr_prio = 1'b1;
        wait_r_accept(tag);
        if (addr[31:9] != '0) finish_r(tag, 1, 32'h0, SLVERR, 0, hold);
        else                  finish_r(tag, 2, ref_mem[idx], OKAY, 1, hold);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int hold, input string tag);
        drive_w(addr, data, strb);
        write_pending(addr, data, strb, hold, tag);
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold, input string tag);
        drive_r(addr);
        read_pending(addr, hold, tag);
    endtask

    task automatic contend(input logic [31:0] waddr, input logic [31:0] wdata, input logic [3:0] wstrb,
                           input logic [31:0] raddr, input int hold, input string tag);
        bit w_first = wr_prio;
        drive_w(waddr, wdata, wstrb);
        drive_r(raddr);
        #1;
        check({tag, "_arb_aw"}, {31'b0, AWREADY}, {31'b0, w_first});
        check({tag, "_arb_ar"}, {31'b0, ARREADY}, {31'b0, !w_first});
        if (w_first) begin
            write_pending(waddr, wdata, wstrb, hold, {tag, "_w"});
            read_pending(raddr, 0, {tag, "_r"});
        end else begin
            read_pending(raddr, hold, {tag, "_r"});
            write_pending(waddr, wdata, wstrb, 0, {tag, "_w"});
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a = {23'b0, 7'($urandom_range(0, 127)), 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 9) == 0) a = a | (32'h200 << $urandom_range(0, 22));
        return a;
    endfunction

    function automatic logic [3:0] rand_strb();
        int k = $urandom_range(0, 5);
        if (k == 0) return 4'h0;
        if (k < 3)  return 4'hF;
        return 4'($urandom_range(1, 14));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end

        // Reset state, with all valids raised to prove readies stay low.
        RST_N = 1'b0;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        #12;
        check("rst_awready", {31'b0, AWREADY}, 32'd0);
        check("rst_wready", {31'b0, WREADY}, 32'd0);
        check("rst_arready", {31'b0, ARREADY}, 32'd0);
        check("rst_valids", {30'b0, BVALID, RVALID}, 32'd0);
        check("rst_mem_strobes", {30'b0, MEM_CS, MEM_WE}, 32'd0);
        check("rst_mem_addr", {25'b0, MEM_ADDR}, 32'd0);
        check("rst_mem_wdata", MEM_WDATA, 32'd0);
        check("rst_rdata", RDATA, 32'd0);
        check("rst_resps", {28'b0, BRESP, RRESP}, 32'd0);
        apply_reset();

        // Directed: full write, readback, partial write, out-of-range.
        do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, "w_full");
        check("w_full_mem_addr", {25'b0, last_we_addr}, 32'd4);
        do_read(32'h10, 0, "r_full");
        do_write(32'h10, 32'h11223344, 4'h3, 0, "w_part");
        do_read(32'h13, 0, "r_part");
        check("part_model", ref_mem[4], 32'hDEAD3344);
        do_read(32'h200, 0, "r_oor");
        do_write(32'h200, 32'hCAFEF00D, 4'hF, 0, "w_oor");
        do_write(32'h24, 32'h55AA55AA, 4'h0, 0, "w_nostrb");

        // Arbitration from a fresh reset: write first, then order alternates.
        apply_reset();
        contend(32'h20, 32'h01020304, 4'hF, 32'h20, 0, "arb1");
        contend(32'h30, 32'hA5A5A5A5, 4'hC, 32'h20, 0, "arb2");

        // Long BREADY stall with a read waiting behind it.
        apply_reset();
        contend(32'h40, 32'h0BADCAFE, 4'hF, 32'h40, 5, "stall");

        // Reset asserted while the RMW read is in flight.
        drive_w(32'h24, 32'hFFFFFFFF, 4'h6);
        wait_w_accept("rst_rmw");
        ARVALID = 1'b1;
        #1 RST_N = 1'b0;
        #1;
        check("rst_rmw_strobes", {30'b0, MEM_CS, MEM_WE}, 32'd0);
        check("rst_rmw_readies", {29'b0, AWREADY, WREADY, ARREADY}, 32'd0);
        check("rst_rmw_addr", {25'b0, MEM_ADDR}, 32'd0);
        ARVALID = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        wr_prio = 1'b1;
        begin
            bit seen_b = 1'b0;
            repeat (4) begin
                @(negedge CLK);
                if (BVALID) seen_b = 1'b1;
            end
            check("rst_rmw_no_b", {31'b0, seen_b}, 32'd0);
        end
        check("rst_rmw_word", ram[9], ref_mem[9]);
        check("rst_rmw_no_we", we_cnt, 0);
        contend(32'h8, 32'h77777777, 4'hF, 32'h8, 0, "arb_post_rst");

        // Randomized mix against the reference model.
        for (int t = 0; t < 60; t++) begin
            int k = $urandom_range(0, 9);
            int hold = $urandom_range(0, 3);
            if (k < 2)
                contend(rand_addr(), $urandom, rand_strb(), rand_addr(), hold, $sformatf("rnd%0d_c", t));
            else if (k < 6)
                do_write(rand_addr(), $urandom, rand_strb(), hold, $sformatf("rnd%0d_w", t));
            else
                do_read(rand_addr(), hold, $sformatf("rnd%0d_r", t));
        end

        // Final sweep of the whole RAM against the model.
        for (int i = 0; i < 128; i++)
            check($sformatf("final_word%0d", i), ram[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
